// File: rtl/ring_mem_client.sv
`default_nettype none
// ============================================================================
// Module      : ring_mem_client
// Description : Ring station that turns one client memory request into an
//               Address (+ four WriteData) burst on the ring once it holds
//               the token. It also collects four read-return words into a
//               128-bit completion.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_mem_client #(
    parameter logic [3:0] MY_ID = 4'd1
) (
    input  logic         clock,
    input  logic         reset,
    // upstream ring slot
    input  logic [31:0]  RingIn,
    input  logic [3:0]   SlotTypeIn,
    input  logic [3:0]   SourceIn,
    // downstream ring slot (registered)
    output logic [31:0]  RingOut,
    output logic [3:0]   SlotTypeOut,
    output logic [3:0]   SourceOut,
    // memory read-return path
    input  logic [31:0]  RDreturn,
    input  logic [3:0]   RDdest,
    // client request handshake
    input  logic         reqValid,
    input  logic         reqWrite,
    input  logic [25:0]  reqAddr,
    input  logic [127:0] reqData,
    output logic         reqReady,
    // read completion
    output logic         rdValid,
    output logic [127:0] rdData,
    // sticky protocol violation
    output logic         protoErr
);

    // Shared ring slot-type encodings
    localparam logic [3:0] c_SLOT_NULL      = 4'd0;
    localparam logic [3:0] c_SLOT_TOKEN     = 4'd1;
    localparam logic [3:0] c_SLOT_ADDRESS   = 4'd2;
    localparam logic [3:0] c_SLOT_WRITEDATA = 4'd3;

    typedef enum logic [2:0] {
        S_FWD  = 3'd0,
        S_ADDR = 3'd1,
        S_WD0  = 3'd2,
        S_WD1  = 3'd3,
        S_WD2  = 3'd4,
        S_WD3  = 3'd5,
        S_TOK  = 3'd6
    } state_t;

    state_t        r_state;
    logic [31:0]   r_ringOut;
    logic [3:0]    r_slotOut;
    logic [3:0]    r_srcOut;

    logic          r_pending;
    logic          r_write;
    logic [25:0]   r_addr;
    logic [127:0]  r_data;

    logic          r_readOut;
    logic [1:0]    r_rcnt;
    logic [95:0]   r_rbuf;
    logic          r_rdValid;
    logic [127:0]  r_rdData;
    logic          r_protoErr;

    logic          w_ready;
    logic          w_accept;
    logic [31:0]   w_addrWord;
    logic          w_inBad;
    logic          w_ringErr;
    logic          w_setReadOut;
    logic          w_rdHit;

    // Only one request in flight at a time, including the read-return phase
    assign w_ready      = !r_pending && !r_readOut;
    assign w_accept     = reqValid && w_ready;
    // Bit 28 marks a read
    assign w_addrWord   = {3'b000, ~r_write, 2'b00, r_addr};
    // While we own the ring, anything other than Null or our own returning slot is a violation
    assign w_inBad      = (SlotTypeIn == c_SLOT_TOKEN) ||
                          ((SlotTypeIn != c_SLOT_NULL) && (SourceIn != MY_ID));
    assign w_ringErr    = (r_state != S_FWD) && w_inBad;
    assign w_setReadOut = (r_state == S_ADDR) && !r_write;
    assign w_rdHit      = (RDdest == MY_ID);

    // Ring FSM: forwards/strips slots, or emits our burst after capturing the token
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_FWD;
            r_ringOut <= 32'd0;
            r_slotOut <= c_SLOT_NULL;
            r_srcOut  <= 4'd0;
            r_pending <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= 26'd0;
            r_data    <= 128'd0;
        end else begin
            // Acceptance only happens with nothing pending, so it never races the TOK clear
            if (w_accept) begin
                r_pending <= 1'b1;
                r_write   <= reqWrite;
                r_addr    <= reqAddr;
                r_data    <= reqData;
            end
            case (r_state)
                S_FWD: begin
                    if (r_pending && (SlotTypeIn == c_SLOT_TOKEN)) begin
                        // Token is captured; its slot becomes empty
                        r_state   <= S_ADDR;
                        r_ringOut <= 32'd0;
                        r_slotOut <= c_SLOT_NULL;
                        r_srcOut  <= 4'd0;
                    end else if (SourceIn == MY_ID) begin
                        // Our own slot has travelled the full ring: strip it
                        r_ringOut <= 32'd0;
                        r_slotOut <= c_SLOT_NULL;
                        r_srcOut  <= 4'd0;
                    end else begin
                        r_ringOut <= RingIn;
                        r_slotOut <= SlotTypeIn;
                        r_srcOut  <= SourceIn;
                    end
                end
                S_ADDR: begin
                    r_ringOut <= w_addrWord;
                    r_slotOut <= c_SLOT_ADDRESS;
                    r_srcOut  <= MY_ID;
                    r_state   <= r_write ? S_WD0 : S_TOK;
                end
                S_WD0: begin
                    r_ringOut <= r_data[31:0];
                    r_slotOut <= c_SLOT_WRITEDATA;
                    r_srcOut  <= MY_ID;
                    r_state   <= S_WD1;
                end
                S_WD1: begin
                    r_ringOut <= r_data[63:32];
                    r_slotOut <= c_SLOT_WRITEDATA;
                    r_srcOut  <= MY_ID;
                    r_state   <= S_WD2;
                end
                S_WD2: begin
                    r_ringOut <= r_data[95:64];
                    r_slotOut <= c_SLOT_WRITEDATA;
                    r_srcOut  <= MY_ID;
                    r_state   <= S_WD3;
                end
                S_WD3: begin
                    r_ringOut <= r_data[127:96];
                    r_slotOut <= c_SLOT_WRITEDATA;
                    r_srcOut  <= MY_ID;
                    r_state   <= S_TOK;
                end
                S_TOK: begin
                    r_ringOut <= 32'd0;
                    r_slotOut <= c_SLOT_TOKEN;
                    r_srcOut  <= 4'd0;
                    r_pending <= 1'b0;
                    r_state   <= S_FWD;
                end
                default: begin
                    r_ringOut <= 32'd0;
                    r_slotOut <= c_SLOT_NULL;
                    r_srcOut  <= 4'd0;
                    r_state   <= S_FWD;
                end
            endcase
        end
    end

    // Read-return capture, outstanding tracking and the sticky error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_readOut  <= 1'b0;
            r_rcnt     <= 2'd0;
            r_rbuf     <= 96'd0;
            r_rdValid  <= 1'b0;
            r_rdData   <= 128'd0;
            r_protoErr <= 1'b0;
        end else begin
            r_rdValid <= 1'b0;
            if (w_ringErr) begin
                r_protoErr <= 1'b1;
            end
            if (w_rdHit) begin
                if (r_readOut) begin
                    // Words 0..2 go to a staging buffer so rdData holds the previous read meanwhile
                    case (r_rcnt)
                        2'd0: r_rbuf[31:0]  <= RDreturn;
                        2'd1: r_rbuf[63:32] <= RDreturn;
                        2'd2: r_rbuf[95:64] <= RDreturn;
                        default: begin
                            r_rdData  <= {RDreturn, r_rbuf};
                            r_rdValid <= 1'b1;
                            r_readOut <= 1'b0;
                        end
                    endcase
                    r_rcnt <= r_rcnt + 2'd1;
                end else begin
                    // Unsolicited return word is dropped
                    r_protoErr <= 1'b1;
                end
            end
            // Cannot coincide with the completion above: a new read needs reqReady first
            if (w_setReadOut) begin
                r_readOut <= 1'b1;
            end
        end
    end

    assign RingOut     = r_ringOut;
    assign SlotTypeOut = r_slotOut;
    assign SourceOut   = r_srcOut;
    assign reqReady    = w_ready;
    assign rdValid     = r_rdValid;
    assign rdData      = r_rdData;
    assign protoErr    = r_protoErr;

endmodule
`default_nettype wire

// File: tb/tb_ring_mem_client.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_mem_client
// Description : Self-checking bench for ring_mem_client: directed scenarios
//               with literal expectations plus randomized ring traffic,
//               compared every cycle against a queue-based slot model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_mem_client;

    localparam logic [3:0] ID     = 4'd1;
    localparam logic [3:0] T_NULL = 4'd0;
    localparam logic [3:0] T_TOK  = 4'd1;
    localparam logic [3:0] T_ADDR = 4'd2;
    localparam logic [3:0] T_WD   = 4'd3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  RingIn = '0;
    logic [3:0]   SlotTypeIn = '0;
    logic [3:0]   SourceIn = '0;
    logic [31:0]  RingOut;
    logic [3:0]   SlotTypeOut;
    logic [3:0]   SourceOut;
    logic [31:0]  RDreturn = '0;
    logic [3:0]   RDdest = '0;
    logic         reqValid = 1'b0;
    logic         reqWrite = 1'b0;
    logic [25:0]  reqAddr = '0;
    logic [127:0] reqData = '0;
    logic         reqReady;
    logic         rdValid;
    logic [127:0] rdData;
    logic         protoErr;

    ring_mem_client #(.MY_ID(ID)) dut (
        .clock(clock), .reset(reset),
        .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
        .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
        .RDreturn(RDreturn), .RDdest(RDdest),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr),
        .reqData(reqData), .reqReady(reqReady),
        .rdValid(rdValid), .rdData(rdData), .protoErr(protoErr)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0]  t;
        logic [31:0] d;
        logic [3:0]  s;
    } slot_t;

    slot_t        mq[$];          // burst slots still to be emitted
    slot_t        m_out = '0;
    bit           m_pend = 0, m_wr = 0, m_rout = 0, m_rv = 0, m_err = 0;
    logic [25:0]  m_addr = '0;
    logic [127:0] m_data = '0, m_rd = '0;
    logic [31:0]  m_words[4];
    int           m_cnt = 0;

    logic         c_rst, c_rv, c_wr;
    logic [25:0]  c_ad;
    logic [127:0] c_dt;
    logic [31:0]  c_ri, c_rdr;
    logic [3:0]   c_st, c_si, c_rdd;

    task automatic model_step();
        bit    acc;
        slot_t si;
        slot_t s;
        if (c_rst) begin
            mq.delete();
            m_out = '0; m_pend = 0; m_wr = 0; m_rout = 0; m_rv = 0; m_err = 0;
            m_addr = '0; m_data = '0; m_rd = '0; m_cnt = 0;
        end else begin
            acc  = c_rv && !m_pend && !m_rout;
            m_rv = 0;
            if (c_rdd == ID) begin
                if (m_rout) begin
                    m_words[m_cnt] = c_rdr;
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_rd   = {m_words[3], m_words[2], m_words[1], m_words[0]};
                        m_rv   = 1;
                        m_rout = 0;
                        m_cnt  = 0;
                    end
                end else begin
                    m_err = 1;
                end
            end
            si = '{c_st, c_ri, c_si};
            if (mq.size() != 0) begin
                if (si.t == T_TOK || (si.t != T_NULL && si.s != ID)) m_err = 1;
                s = mq.pop_front();
                m_out = s;
                if (s.t == T_ADDR && s.d[28]) m_rout = 1;
                if (s.t == T_TOK) m_pend = 0;
            end else if (m_pend && si.t == T_TOK) begin
                m_out = '0;
                mq.push_back('{T_ADDR, {3'b000, ~m_wr, 2'b00, m_addr}, ID});
                if (m_wr) begin
                    for (int k = 0; k < 4; k++) mq.push_back('{T_WD, m_data[32*k +: 32], ID});
                end
                mq.push_back('{T_TOK, 32'h0, 4'h0});
            end else if (si.s == ID) begin
                m_out = '0;
            end else begin
                m_out = si;
            end
            if (acc) begin
                m_pend = 1; m_wr = c_wr; m_addr = c_ad; m_data = c_dt;
            end
        end
    endtask

    // Compare process: advance the model on each edge and check every output
    initial begin
        forever begin
            @(posedge clock);
            c_rst = reset; c_rv = reqValid; c_wr = reqWrite; c_ad = reqAddr; c_dt = reqData;
            c_ri = RingIn; c_st = SlotTypeIn; c_si = SourceIn; c_rdr = RDreturn; c_rdd = RDdest;
            #1;
            model_step();
            chk("m_slottype", 128'(SlotTypeOut), 128'(m_out.t));
            chk("m_ringout",  128'(RingOut),     128'(m_out.d));
            chk("m_source",   128'(SourceOut),   128'(m_out.s));
            chk("m_reqready", 128'(reqReady),    128'(!m_pend && !m_rout));
            chk("m_rdvalid",  128'(rdValid),     128'(m_rv));
            chk("m_rddata",   rdData,            m_rd);
            chk("m_protoerr", 128'(protoErr),    128'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drv(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
        SlotTypeIn = t; RingIn = d; SourceIn = s;
    endtask

    task automatic req(input logic w, input logic [25:0] a, input logic [127:0] d);
        reqValid = 1'b1; reqWrite = w; reqAddr = a; reqData = d;
    endtask

    logic [3:0]  wr_t[6] = '{T_ADDR, T_WD, T_WD, T_WD, T_WD, T_TOK};
    logic [31:0] wr_d[6] = '{32'h00000040, 32'h11111111, 32'h22222222,
                             32'h33333333, 32'h44444444, 32'h0};
    logic [3:0]  wr_s[6] = '{ID, ID, ID, ID, ID, 4'd0};
    logic [31:0] rw[4]   = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};

    initial begin
        // reset state
        tick(); tick();
        chk("rst_slottype", 128'(SlotTypeOut), 128'(T_NULL));
        chk("rst_ringout",  128'(RingOut), 128'(0));
        chk("rst_protoerr", 128'(protoErr), 128'(0));
        chk("rst_rddata",   rdData, 128'(0));
        reset = 1'b0;
        tick();
        chk("rst_reqready", 128'(reqReady), 128'(1));

        // write burst
        req(1'b1, 26'h0000040, 128'h44444444_33333333_22222222_11111111);
        tick();
        reqValid = 1'b0;
        chk("wr_ready_low", 128'(reqReady), 128'(0));
        drv(T_TOK, 32'h0, 4'h0);
        tick();
        chk("wr_tok_consumed", 128'(SlotTypeOut), 128'(T_NULL));
        drv(T_NULL, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wr_seq_type", 128'(SlotTypeOut), 128'(wr_t[i]));
            chk("wr_seq_data", 128'(RingOut),     128'(wr_d[i]));
            chk("wr_seq_src",  128'(SourceOut),   128'(wr_s[i]));
        end
        chk("wr_ready_back", 128'(reqReady), 128'(1));

        // read burst, with requests ignored while outstanding
        req(1'b0, 26'h3FFFFFF, 128'h0);
        tick();
        reqValid = 1'b0;
        drv(T_TOK, 32'h0, 4'h0);
        tick();
        chk("rd_tok_consumed", 128'(SlotTypeOut), 128'(T_NULL));
        drv(T_NULL, 32'h0, 4'h0);
        tick();
        chk("rd_addr_type", 128'(SlotTypeOut), 128'(T_ADDR));
        chk("rd_addr_word", 128'(RingOut), 128'(32'h13FFFFFF));
        chk("rd_addr_src",  128'(SourceOut), 128'(ID));
        tick();
        chk("rd_tok_type", 128'(SlotTypeOut), 128'(T_TOK));
        chk("rd_tok_src",  128'(SourceOut), 128'(0));
        chk("rd_busy_ready", 128'(reqReady), 128'(0));
        req(1'b1, 26'h0000005, 128'h5);
        drv(T_TOK, 32'h0, 4'h0);
        tick();
        chk("rd_ignore_tokfwd", 128'(SlotTypeOut), 128'(T_TOK));
        chk("rd_ignore_ready", 128'(reqReady), 128'(0));
        drv(T_NULL, 32'h0, 4'h0);
        tick();
        reqValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            RDdest = ID; RDreturn = rw[i];
            tick();
        end
        RDdest = 4'd0;
        chk("rd_valid", 128'(rdValid), 128'(1));
        chk("rd_data", rdData, {rw[3], rw[2], rw[1], rw[0]});
        chk("rd_ready_back", 128'(reqReady), 128'(1));
        tick();
        chk("rd_valid_pulse", 128'(rdValid), 128'(0));
        chk("rd_data_hold", rdData, {rw[3], rw[2], rw[1], rw[0]});

        // forwarding and stripping
        drv(T_TOK, 32'h0, 4'h0);
        tick();
        chk("fwd_tok", 128'(SlotTypeOut), 128'(T_TOK));
        drv(T_ADDR, 32'h12345678, 4'd3);
        tick();
        chk("fwd_addr_type", 128'(SlotTypeOut), 128'(T_ADDR));
        chk("fwd_addr_data", 128'(RingOut), 128'(32'h12345678));
        chk("fwd_addr_src",  128'(SourceOut), 128'(3));
        drv(T_WD, 32'hDEADBEEF, ID);
        tick();
        chk("strip_type", 128'(SlotTypeOut), 128'(T_NULL));
        chk("strip_data", 128'(RingOut), 128'(0));

        // token coinciding with acceptance is forwarded; next token consumed
        req(1'b0, 26'h0000123, 128'h0);
        drv(T_TOK, 32'h0, 4'h0);
        tick();
        reqValid = 1'b0;
        chk("bnd_tok_fwd", 128'(SlotTypeOut), 128'(T_TOK));
        tick();
        chk("bnd_tok_consumed", 128'(SlotTypeOut), 128'(T_NULL));
        drv(T_NULL, 32'h0, 4'h0);
        tick();
        chk("bnd_addr_word", 128'(RingOut), 128'(32'h10000123));
        tick();
        for (int i = 0; i < 4; i++) begin
            RDdest = ID; RDreturn = $urandom;
            tick();
        end
        RDdest = 4'd0;
        tick();

        // foreign slot during WD1
        chk("err_clean", 128'(protoErr), 128'(0));
        req(1'b1, 26'h0000008, {$urandom, $urandom, $urandom, $urandom});
        tick();
        reqValid = 1'b0;
        drv(T_TOK, 32'h0, 4'h0);
        tick();
        drv(T_NULL, 32'h0, 4'h0);
        tick(); tick();
        drv(T_WD, 32'h00000BAD, 4'd3);
        tick();
        drv(T_NULL, 32'h0, 4'h0);
        chk("err_wd1", 128'(protoErr), 128'(1));
        repeat (5) tick();
        chk("err_sticky", 128'(protoErr), 128'(1));
        reset = 1'b1; tick(); reset = 1'b0; tick();
        chk("err_cleared", 128'(protoErr), 128'(0));
        RDdest = ID; RDreturn = 32'h77777777;
        tick();
        RDdest = 4'd0;
        chk("err_rd_unsolicited", 128'(protoErr), 128'(1));
        chk("err_rd_novalid", 128'(rdValid), 128'(0));
        tick();
        chk("err_rd_sticky", 128'(protoErr), 128'(1));
        reset = 1'b1; tick(); reset = 1'b0; tick();

        // reset during WD2 abandons the burst
        req(1'b1, 26'h0000100, {$urandom, $urandom, $urandom, $urandom});
        tick();
        reqValid = 1'b0;
        drv(T_TOK, 32'h0, 4'h0);
        tick();
        drv(T_NULL, 32'h0, 4'h0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk("rstwd2_type", 128'(SlotTypeOut), 128'(T_NULL));
        chk("rstwd2_data", 128'(RingOut), 128'(0));
        chk("rstwd2_src",  128'(SourceOut), 128'(0));
        chk("rstwd2_ready", 128'(reqReady), 128'(1));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstwd2_no_tok", 128'(SlotTypeOut), 128'(T_NULL));
        end
        drv(T_TOK, 32'h0, 4'h0);
        tick();
        chk("rstwd2_fwd_state", 128'(SlotTypeOut), 128'(T_TOK));

        // randomized protocol-clean traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            reset = ($urandom_range(0, 599) == 0);
            r = $urandom_range(0, 99);
            if (mq.size() != 0) begin
                if (r < 50) drv(T_NULL, 32'h0, 4'h0);
                else        drv(4'($urandom_range(2, 3)), $urandom, ID);
            end else begin
                if (r < 25)      drv(T_TOK, 32'h0, 4'h0);
                else if (r < 50) drv(4'($urandom_range(2, 3)), $urandom, 4'($urandom_range(2, 15)));
                else if (r < 65) drv(4'($urandom_range(2, 3)), $urandom, ID);
                else             drv(T_NULL, 32'h0, 4'h0);
            end
            reqValid = ($urandom_range(0, 3) == 0);
            reqWrite = 1'($urandom_range(0, 1));
            reqAddr  = 26'($urandom);
            reqData  = {$urandom, $urandom, $urandom, $urandom};
            if (m_rout && ($urandom_range(0, 1) == 1)) begin
                RDdest = ID; RDreturn = $urandom;
            end else begin
                RDdest = 4'($urandom_range(2, 15)); RDreturn = $urandom;
            end
            tick();
        end
        reset = 1'b0; reqValid = 1'b0; RDdest = 4'd0;
        drv(T_NULL, 32'h0, 4'h0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
